// File: rtl/emb_loader_pkg.sv
// Shared definitions for the embedding loader: default geometry, state
// encoding and the registered strobe bundle.
package emb_loader_pkg;

    localparam int unsigned D_LEN_DEF       = 32;
    localparam int unsigned ELE_NUM_DEF     = 128;
    localparam int unsigned TIMEOUT_CYC_DEF = 4096;
    localparam int unsigned WAIT_CNT_W      = 16;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        FIRE   = 2'd2,
        WAIT   = 2'd3
    } state_t;

    // One-cycle strobes, all registered together.
    typedef struct packed {
        logic ip_start;
        logic sim_valid;
        logic err_len;
        logic err_timeout;
    } pulse_t;

endpackage

// File: rtl/emb_loader_if.sv
// Valid/ready stream of FP32 embedding words into the loader.
interface emb_loader_if
    import emb_loader_pkg::*;
#(
    parameter int unsigned D_Len = D_LEN_DEF
);
    logic             s_valid;
    logic             s_ready;
    logic [D_Len-1:0] s_data;
    logic             s_last;
    logic             keep_ref;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        output keep_ref,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        input  keep_ref,
        output s_ready
    );
endinterface

// File: rtl/emb_loader.sv
// Embedding loader: assembles probe (vct1) and reference (vct2) vectors from
// a word stream, kicks the similarity core and returns its result.
// Optional: define LOADER_TIMEOUT_EN to abort WAIT after TIMEOUT_CYC cycles.
module emb_loader
    import emb_loader_pkg::*;
#(
    parameter int unsigned D_Len       = D_LEN_DEF,
    parameter int unsigned Ele_Num     = ELE_NUM_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    emb_loader_if.slave              s_if,
    output logic [D_Len*Ele_Num-1:0] vct1,
    output logic [D_Len*Ele_Num-1:0] vct2,
    output logic                     ip_start,
    input  logic                     ip_done,
    input  logic [D_Len-1:0]         ip_result,
    output logic                     sim_valid,
    output logic [D_Len-1:0]         sim_result,
    output logic                     ref_loaded,
    output logic                     err_len,
    output logic                     err_timeout
);

    localparam int unsigned    IDX_W    = (Ele_Num > 1) ? $clog2(Ele_Num) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(Ele_Num - 1);

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic                          ready_q, ready_d;
    logic                          ref_q, ref_d;
    pulse_t                        pulse_q, pulse_d;
    logic [Ele_Num-1:0][D_Len-1:0] v1_q, v2_q;
    logic [D_Len-1:0]              res_q;
    logic                          accept_c, last_idx_c;
    logic                          wr_a_c, wr_b_c, capture_c;
    logic                          timeout_hit_c;

`ifdef LOADER_TIMEOUT_EN
    logic [WAIT_CNT_W-1:0] wait_cnt_q;

    // Counts WAIT cycles; held at zero outside WAIT so it is clear on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if (state_q != WAIT) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    assign timeout_hit_c = (wait_cnt_q == WAIT_CNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^WAIT_CNT_W'(TIMEOUT_CYC);
    assign timeout_hit_c      = 1'b0;
`endif

    // Next-state, index, framing and strobe decode.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ref_d      = ref_q;
        pulse_d    = '0;
        wr_a_c     = 1'b0;
        wr_b_c     = 1'b0;
        capture_c  = 1'b0;
        accept_c   = s_if.s_valid & ready_q;
        last_idx_c = (idx_q == IDX_LAST);

        case (state_q)
            LOAD_A, LOAD_B: begin
                if (accept_c) begin
                    wr_a_c = (state_q == LOAD_A);
                    wr_b_c = (state_q == LOAD_B);
                    if (s_if.s_last != last_idx_c) begin
                        // Misframed vector: restart it in the same phase.
                        idx_d           = '0;
                        pulse_d.err_len = 1'b1;
                        if (state_q == LOAD_B) begin
                            ref_d = 1'b0;
                        end
                    end else if (last_idx_c) begin
                        idx_d = '0;
                        if (state_q == LOAD_B) begin
                            ref_d   = 1'b1;
                            state_d = FIRE;
                        end else if (s_if.keep_ref && ref_q) begin
                            state_d = FIRE;
                        end else begin
                            state_d = LOAD_B;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            FIRE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (ip_done) begin
                    capture_c         = 1'b1;
                    pulse_d.sim_valid = 1'b1;
                    state_d           = LOAD_A;
                end else if (timeout_hit_c) begin
                    pulse_d.err_timeout = 1'b1;
                    state_d             = LOAD_A;
                end
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase

        pulse_d.ip_start = (state_d == FIRE);
        ready_d          = (state_d == LOAD_A) || (state_d == LOAD_B);
    end

    // Control state and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            idx_q   <= '0;
            ready_q <= 1'b0;
            ref_q   <= 1'b0;
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            ref_q   <= ref_d;
            pulse_q <= pulse_d;
        end
    end

    // Vector storage and result capture; untouched outside the load phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= '0;
            v2_q  <= '0;
            res_q <= '0;
        end else begin
            if (wr_a_c) begin
                v1_q[idx_q] <= s_if.s_data;
            end
            if (wr_b_c) begin
                v2_q[idx_q] <= s_if.s_data;
            end
            if (capture_c) begin
                res_q <= ip_result;
            end
        end
    end

    assign s_if.s_ready = ready_q;
    assign vct1         = v1_q;
    assign vct2         = v2_q;
    assign sim_result   = res_q;
    assign ref_loaded   = ref_q;
    assign ip_start     = pulse_q.ip_start;
    assign sim_valid    = pulse_q.sim_valid;
    assign err_len      = pulse_q.err_len;
    assign err_timeout  = pulse_q.err_timeout;

endmodule

// File: tb/tb_emb_loader.sv
// Directed bench for emb_loader with an IP stub and a result scoreboard.
module tb_emb_loader;
    import emb_loader_pkg::*;

    localparam int unsigned DL = 32;
    localparam int unsigned EN = 128;
    localparam int unsigned TO = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    emb_loader_if #(.D_Len(DL)) s_if ();

    logic [DL*EN-1:0] vct1, vct2;
    logic             ip_start, ip_done, sim_valid, ref_loaded, err_len, err_timeout;
    logic [DL-1:0]    ip_result, sim_result;

    emb_loader #(.D_Len(DL), .Ele_Num(EN), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_if        (s_if),
        .vct1        (vct1),
        .vct2        (vct2),
        .ip_start    (ip_start),
        .ip_done     (ip_done),
        .ip_result   (ip_result),
        .sim_valid   (sim_valid),
        .sim_result  (sim_result),
        .ref_loaded  (ref_loaded),
        .err_len     (err_len),
        .err_timeout (err_timeout)
    );

    // IP stub: done five cycles after the start pulse.
    bit          stub_en = 1'b1;
    logic [31:0] stub_result = 32'h3f800000;
    logic [2:0]  stub_cnt = '0;
    always @(posedge clk) begin
        if (ip_start && stub_en) stub_cnt <= 3'd5;
        else if (stub_cnt != 3'd0) stub_cnt <= stub_cnt - 3'd1;
    end
    assign ip_done   = stub_en && (stub_cnt == 3'd1);
    assign ip_result = stub_result;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] sb_q[$];
    int cyc = 0, start_cnt = 0, start_cyc = 0, sim_cnt = 0, sim_cyc = 0;
    int err_cnt = 0, to_cnt = 0, to_cyc = 0, beats = 0, last_cyc = 0;
    bit hs_pre, last_pre;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: note the handshake before the edge, observe outputs after it.
    task automatic tick();
        hs_pre   = s_if.s_valid && s_if.s_ready;
        last_pre = s_if.s_last;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (hs_pre) begin
            beats++;
            if (last_pre) last_cyc = cyc;
        end
        if (ip_start) begin start_cnt++; start_cyc = cyc; end
        if (err_len) err_cnt++;
        if (err_timeout) begin to_cnt++; to_cyc = cyc; end
        if (sim_valid) begin
            sim_cnt++;
            sim_cyc = cyc;
            if (sb_q.size() == 0) check("unexpected_sim_valid", 32'd1, 32'd0);
            else check("sim_result", sim_result, sb_q.pop_front());
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last, input bit gap);
        int guard;
        if (gap) begin
            s_if.s_valid = 1'b0;
            tick();
        end
        s_if.s_valid = 1'b1;
        s_if.s_data  = d;
        s_if.s_last  = last;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!hs_pre && guard < 50);
        if (!hs_pre) check("handshake_timeout", 32'd0, 32'd1);
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
    endtask

    task automatic send_vec(input int n, input int last_at, input logic [31:0] base,
                            input logic [31:0] inc, input bit gaps);
        for (int i = 0; i < n; i++) begin
            send_beat(base + inc * 32'(i), (i == last_at),
                      gaps && ($urandom_range(0, 3) == 0));
        end
    endtask

    task automatic wait_sim();
        int s0 = sim_cnt;
        int guard = 0;
        while (sim_cnt == s0 && guard < 100) begin
            tick();
            guard++;
        end
        if (sim_cnt == s0) check("sim_valid_timeout", 32'd0, 32'd1);
    endtask

    function automatic int bad_words(input logic [DL*EN-1:0] v, input logic [31:0] base,
                                     input logic [31:0] inc);
        int n = 0;
        for (int i = 0; i < int'(EN); i++) begin
            if (v[i*DL +: DL] !== base + inc * 32'(i)) n++;
        end
        return n;
    endfunction

    initial begin
        int e0, st0, b0, s0, chg, rdy_bad, guard;
        logic [DL*EN-1:0] snap1, snap2;

        s_if.s_valid  = 1'b0;
        s_if.s_data   = '0;
        s_if.s_last   = 1'b0;
        s_if.keep_ref = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_s_ready", s_if.s_ready, 0);
        check("rst_vct1_any", |vct1, 0);
        check("rst_vct2_any", |vct2, 0);
        check("rst_sim_result", sim_result, 0);
        check("rst_sim_valid", sim_valid, 0);
        check("rst_ip_start", ip_start, 0);
        check("rst_err_len", err_len, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_ref_loaded", ref_loaded, 0);
        rst_n = 1'b1;
        tick();
        check("release_s_ready", s_if.s_ready, 1);

        // Identical vectors A and B.
        send_vec(EN, EN - 1, 32'h3f800000, 0, 0);
        check("a_done_no_start", start_cnt, 0);
        check("a_done_ready_in_b", s_if.s_ready, 1);
        sb_q.push_back(32'h3f800000);
        send_vec(EN, EN - 1, 32'h3f800000, 0, 0);
        check("start_after_b_last", start_cyc, last_cyc);
        check("fire_s_ready", s_if.s_ready, 0);
        wait_sim();
        check("sim_latency", sim_cyc - start_cyc, 6);
        tick();
        check("sim_valid_single", sim_valid, 0);
        check("start_single", start_cnt, 1);
        check("ident_vct1", bad_words(vct1, 32'h3f800000, 0), 0);
        check("ident_vct2", bad_words(vct2, 32'h3f800000, 0), 0);
        check("ident_ref_loaded", ref_loaded, 1);

        // Reference reuse: A only.
        s_if.keep_ref = 1'b1;
        stub_result = 32'h3f000000;
        sb_q.push_back(32'h3f000000);
        b0 = beats;
        send_vec(EN, EN - 1, 0, 1, 0);
        check("reuse_start_after_a", start_cyc, last_cyc);
        check("reuse_start_cnt", start_cnt, 2);
        wait_sim();
        s_if.keep_ref = 1'b0;
        check("reuse_beats", beats - b0, EN);
        check("reuse_vct1", bad_words(vct1, 0, 1), 0);
        check("reuse_vct2_kept", bad_words(vct2, 32'h3f800000, 0), 0);

        // Framing errors in A.
        e0 = err_cnt;
        st0 = start_cnt;
        send_vec(64, 63, 32'h000000aa, 0, 0);
        tick();
        check("early_last_err", err_cnt, e0 + 1);
        send_vec(EN, -1, 32'h000000bb, 0, 0);
        tick();
        check("missing_last_err", err_cnt, e0 + 2);
        send_vec(EN, EN - 1, 32'h00000100, 1, 1);
        check("restart_vct1", bad_words(vct1, 32'h00000100, 1), 0);
        check("restart_in_b", s_if.s_ready, 1);
        check("restart_no_start", start_cnt, st0);
        check("restart_no_err", err_cnt, e0 + 2);

        // Framing error in B clears the reference.
        send_vec(11, 10, 32'h000000cc, 0, 0);
        tick();
        check("b_err", err_cnt, e0 + 3);
        check("b_err_ref_cleared", ref_loaded, 0);

        // Backpressure: gappy B, then valid held through FIRE/WAIT.
        stub_result = 32'h3e99999a;
        sb_q.push_back(32'h3e99999a);
        send_vec(EN, EN - 1, 32'h00000200, 1, 1);
        s_if.s_valid = 1'b1;
        s_if.s_data  = 32'hdeadbeef;
        snap1 = vct1;
        snap2 = vct2;
        b0 = beats;
        s0 = sim_cnt;
        chg = 0;
        rdy_bad = 0;
        guard = 0;
        while (sim_cnt == s0 && guard < 50) begin
            if (s_if.s_ready) rdy_bad++;
            tick();
            if (vct1 !== snap1 || vct2 !== snap2) chg++;
            guard++;
        end
        s_if.s_valid = 1'b0;
        check("bp_sim_seen", sim_cnt, s0 + 1);
        check("bp_ready_low", rdy_bad, 0);
        check("bp_no_beats", beats, b0);
        check("bp_vct_stable", chg, 0);
        check("bp_vct2", bad_words(vct2, 32'h00000200, 1), 0);
        check("bp_ref_loaded", ref_loaded, 1);

        // Reset while waiting on the IP.
        stub_en = 1'b0;
        send_vec(EN, EN - 1, 32'h00000005, 0, 0);
        send_vec(EN, EN - 1, 32'h00000006, 0, 0);
        tick();
        tick();
        s0 = sim_cnt;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("wrst_vct1", |vct1, 0);
        check("wrst_vct2", |vct2, 0);
        check("wrst_ref_loaded", ref_loaded, 0);
        check("wrst_s_ready", s_if.s_ready, 0);
        rst_n = 1'b1;
        stub_en = 1'b1;
        tick();
        s_if.keep_ref = 1'b1;
        st0 = start_cnt;
        send_vec(EN, EN - 1, 32'h00000007, 1, 0);
        check("wrst_enters_b", s_if.s_ready, 1);
        check("wrst_no_start", start_cnt, st0);
        s_if.keep_ref = 1'b0;
        stub_result = 32'h3f400000;
        sb_q.push_back(32'h3f400000);
        send_vec(EN, EN - 1, 32'h00000008, 1, 0);
        wait_sim();
        check("wrst_ref_after", ref_loaded, 1);

`ifdef LOADER_TIMEOUT_EN
        // IP never answers: abort after the timeout.
        stub_en = 1'b0;
        s0 = sim_cnt;
        send_vec(EN, EN - 1, 32'h00000009, 0, 0);
        send_vec(EN, EN - 1, 32'h0000000a, 0, 0);
        guard = 0;
        e0 = to_cnt;
        while (to_cnt == e0 && guard < 5000) begin
            tick();
            guard++;
        end
        check("to_pulse", to_cnt, e0 + 1);
        check("to_latency", to_cyc - last_cyc, TO + 1);
        check("to_no_sim", sim_cnt, s0);
        check("to_back_to_a", s_if.s_ready, 1);
        stub_en = 1'b1;
`else
        check("no_timeout_pulse", to_cnt, 0);
`endif

        tick();
        check("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
